// File: rtl/sccpu_dmem_responder_if.sv
// Data-port bus of the single-cycle CPU, plus the output stream drained by
// an external consumer.
interface sccpu_dmem_responder_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        we;
   logic [31:0] rdata;
   logic [15:0] leds;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;

   // CPU side together with the stream consumer.
   modport master (
      output addr, wdata, we, out_ready,
      input  rdata, leds, out_valid, out_data
   );

   // Responder side.
   modport slave (
      input  addr, wdata, we, out_ready,
      output rdata, leds, out_valid, out_data
   );
endinterface

// File: rtl/sccpu_dmem_responder.sv
// Data-side responder: word RAM plus an I/O page holding a cycle counter,
// an LED register and an output FIFO with a sticky overflow flag.
module sccpu_dmem_responder #(
   parameter int ADDR_W  = 5,
   parameter int FIFO_AW = 2
) (
   input logic                  clock,
   input logic                  reset,
   sccpu_dmem_responder_if.slave bus
);
   localparam int RAM_WORDS = 1 << ADDR_W;
   localparam int DEPTH     = 1 << FIFO_AW;
   localparam int CW        = FIFO_AW + 1;

   localparam logic [2:0] SEL_CYCLE  = 3'd0;
   localparam logic [2:0] SEL_LED    = 3'd1;
   localparam logic [2:0] SEL_FIFO   = 3'd2;
   localparam logic [2:0] SEL_STATUS = 3'd3;
   localparam logic [2:0] SEL_CLR    = 3'd4;

   logic [31:0]        ram_q  [RAM_WORDS];
   logic [31:0]        ram_d  [RAM_WORDS];
   logic [31:0]        fifo_q [DEPTH];
   logic [31:0]        fifo_d [DEPTH];
   logic [31:0]        cycle_q, cycle_d;
   logic [15:0]        leds_q, leds_d;
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic               ovf_q, ovf_d;

   logic               is_io_s;
   logic [2:0]         io_sel_s;
   logic [ADDR_W-1:0]  ram_idx_s;
   logic               io_we_s, ram_we_s;
   logic               push_s, pop_s, push_ok_s, ovf_set_s, ovf_clr_s;
   logic               empty_s, full_s;
   logic [31:0]        status_s, rdata_s;
   logic               addr_unused_s;

   assign is_io_s       = bus.addr[31];
   assign io_sel_s      = bus.addr[4:2];
   assign ram_idx_s     = bus.addr[ADDR_W+1:2];
   // Byte-lane bits and the ignored I/O page bits have no function.
   assign addr_unused_s = ^{bus.addr[30:5], bus.addr[1:0]};

   assign io_we_s   = bus.we & is_io_s;
   assign ram_we_s  = bus.we & ~is_io_s;
   assign empty_s   = (count_q == CW'(1'b0));
   assign full_s    = (count_q == CW'(DEPTH));
   assign pop_s     = ~empty_s & bus.out_ready;
   assign push_s    = io_we_s & (io_sel_s == SEL_FIFO);
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push_ok_s = push_s & (~full_s | pop_s);
   assign ovf_set_s = push_s & full_s & ~pop_s;
   assign ovf_clr_s = io_we_s & (io_sel_s == SEL_CLR) & bus.wdata[0];
   assign status_s  = 32'({ovf_q, full_s, empty_s, count_q});

   // Next-state for counter, LEDs, FIFO bookkeeping and overflow flag.
   always_comb begin
      cycle_d  = cycle_q + 32'd1;
      leds_d   = leds_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (io_we_s && (io_sel_s == SEL_CYCLE)) begin
         cycle_d = bus.wdata;
      end else begin
         cycle_d = cycle_q + 32'd1;
      end
      if (io_we_s && (io_sel_s == SEL_LED)) begin
         leds_d = bus.wdata[15:0];
      end else begin
         leds_d = leds_q;
      end
      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + FIFO_AW'(1'b1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + FIFO_AW'(1'b1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_s})
         2'b10:   count_d = count_q + CW'(1'b1);
         2'b01:   count_d = count_q - CW'(1'b1);
         default: count_d = count_q;
      endcase
      // Set wins over a clear in the same cycle.
      if (ovf_set_s) begin
         ovf_d = 1'b1;
      end else if (ovf_clr_s) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // Next-state for RAM and FIFO storage; writes are suppressed during reset.
   always_comb begin
      ram_d  = ram_q;
      fifo_d = fifo_q;
      if (reset && ram_we_s) begin
         ram_d[ram_idx_s] = bus.wdata;
      end else begin
         ram_d = ram_q;
      end
      if (reset && push_ok_s) begin
         fifo_d[wr_ptr_q] = bus.wdata;
      end else begin
         fifo_d = fifo_q;
      end
   end

   // Control registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         cycle_q  <= 32'd0;
         leds_q   <= 16'd0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         cycle_q  <= cycle_d;
         leds_q   <= leds_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage arrays carry no reset; their contents are don't-care until written.
   always_ff @(posedge clock) begin
      ram_q  <= ram_d;
      fifo_q <= fifo_d;
   end

   // Load mux: same-cycle read of a word being written returns the old value.
   always_comb begin
      rdata_s = 32'd0;
      if (!is_io_s) begin
         rdata_s = ram_q[ram_idx_s];
      end else begin
         case (io_sel_s)
            SEL_CYCLE:  rdata_s = cycle_q;
            SEL_LED:    rdata_s = {16'd0, leds_q};
            SEL_STATUS: rdata_s = status_s;
            default:    rdata_s = 32'd0;
         endcase
      end
   end

   assign bus.rdata     = rdata_s;
   assign bus.leds      = leds_q;
   assign bus.out_valid = ~empty_s;
   assign bus.out_data  = empty_s ? 32'd0 : fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_sccpu_dmem_responder.sv
// Randomized bench for sccpu_dmem_responder with a queue-based reference model.
module tb_sccpu_dmem_responder;
   logic clock = 1'b0;
   logic reset = 1'b0;

   sccpu_dmem_responder_if bus();

   sccpu_dmem_responder #(.ADDR_W(5), .FIFO_AW(2)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state.
   logic [31:0] ram_m   [32];
   bit          known_m [32];
   logic [31:0] cyc_m;
   logic [15:0] leds_m;
   logic [31:0] q_m [$];
   bit          ovf_m;
   bit          init_m = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] status_m();
      int n = q_m.size();
      return {26'd0, ovf_m, (n == 4), (n == 0), 3'(n)};
   endfunction

   // Drive inputs, let them settle, compare combinational outputs to the model.
   task automatic drv(input logic [31:0] a, input logic [31:0] d, input logic w,
                      input logic rdy, input logic rst);
      bus.addr = a; bus.wdata = d; bus.we = w; bus.out_ready = rdy; reset = rst;
      #1;
      if (init_m) begin
         if (!a[31]) begin
            if (known_m[a[6:2]]) chk("ram_rd", bus.rdata, ram_m[a[6:2]]);
         end else begin
            case (a[4:2])
               3'd0:    chk("cycle_rd", bus.rdata, cyc_m);
               3'd1:    chk("led_rd", bus.rdata, {16'd0, leds_m});
               3'd3:    chk("status_rd", bus.rdata, status_m());
               default: chk("zero_rd", bus.rdata, 32'd0);
            endcase
         end
         chk("out_valid", {31'd0, bus.out_valid}, {31'd0, q_m.size() != 0});
         chk("out_data", bus.out_data, (q_m.size() != 0) ? q_m[0] : 32'd0);
         chk("leds", {16'd0, bus.leds}, {16'd0, leds_m});
      end
   endtask

   // Advance one clock edge and apply the same inputs to the model.
   task automatic tick();
      logic [31:0] a, d;
      bit w, rdy, io, popped;
      logic [2:0] sel;
      a = bus.addr; d = bus.wdata; w = bus.we; rdy = bus.out_ready;
      @(posedge clock);
      if (!reset) begin
         cyc_m = 32'd0; leds_m = 16'd0; q_m.delete(); ovf_m = 1'b0; init_m = 1'b1;
      end else begin
         io = a[31]; sel = a[4:2];
         popped = (q_m.size() != 0) && rdy;
         if (popped) void'(q_m.pop_front());
         if (w && io && sel == 3'd0) cyc_m = d; else cyc_m = cyc_m + 32'd1;
         if (w && !io) begin ram_m[a[6:2]] = d; known_m[a[6:2]] = 1'b1; end
         if (w && io && sel == 3'd1) leds_m = d[15:0];
         if (w && io && sel == 3'd4 && d[0]) ovf_m = 1'b0;
         if (w && io && sel == 3'd2) begin
            if (q_m.size() < 4) q_m.push_back(d); else ovf_m = 1'b1;
         end
      end
      @(negedge clock);
   endtask

   task automatic push(input logic [31:0] v, input logic rdy);
      drv(32'h8000_0008, v, 1'b1, rdy, 1'b1); tick();
   endtask

   logic [31:0] exp5 [4];

   initial begin
      bus.addr = 32'd0; bus.wdata = 32'd0; bus.we = 1'b0; bus.out_ready = 1'b0;
      for (int i = 0; i < 32; i++) known_m[i] = 1'b0;

      // Reset, then check reset state.
      drv(32'd0, 32'd0, 1'b0, 1'b0, 1'b0); tick();
      drv(32'd0, 32'd0, 1'b0, 1'b0, 1'b0); tick();
      drv(32'h8000_000C, 32'd0, 1'b0, 1'b0, 1'b1);
      chk("reset_status", bus.rdata, 32'h0000_0008);
      chk("reset_valid", {31'd0, bus.out_valid}, 32'd0);

      // Counter: reads 10 ten cycles after reset, then load and wrap.
      for (int i = 0; i < 10; i++) begin tick(); drv(32'h8000_0000, 32'd0, 1'b0, 1'b0, 1'b1); end
      chk("cycle_10", bus.rdata, 32'd10);
      tick();
      drv(32'h8000_0000, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1); tick();
      drv(32'h8000_0000, 32'd0, 1'b0, 1'b0, 1'b1); chk("cycle_fffe", bus.rdata, 32'hFFFF_FFFE); tick();
      drv(32'h8000_0000, 32'd0, 1'b0, 1'b0, 1'b1); chk("cycle_ffff", bus.rdata, 32'hFFFF_FFFF); tick();
      drv(32'h8000_0000, 32'd0, 1'b0, 1'b0, 1'b1); chk("cycle_wrap", bus.rdata, 32'd0); tick();

      // RAM: old value during write, alias through upper address bits.
      drv(32'h0000_0010, 32'h1111_1111, 1'b1, 1'b0, 1'b1); tick();
      drv(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
      chk("ram_old", bus.rdata, 32'h1111_1111); tick();
      drv(32'h0000_0010, 32'd0, 1'b0, 1'b0, 1'b1); chk("ram_new", bus.rdata, 32'hDEAD_BEEF); tick();
      drv(32'h0000_0090, 32'd0, 1'b0, 1'b0, 1'b1); chk("ram_alias", bus.rdata, 32'hDEAD_BEEF); tick();

      // LED register.
      drv(32'h8000_0004, 32'h1234_5678, 1'b1, 1'b0, 1'b1); tick();
      drv(32'h8000_0004, 32'd0, 1'b0, 1'b0, 1'b1);
      chk("led_read", bus.rdata, 32'h0000_5678);
      chk("led_port", {16'd0, bus.leds}, 32'h0000_5678); tick();

      // FIFO fill and overflow.
      for (int i = 1; i <= 5; i++) push(32'(i), 1'b0);
      drv(32'h8000_000C, 32'd0, 1'b0, 1'b0, 1'b1);
      chk("status_ovf_full", bus.rdata, 32'h0000_0034); tick();
      for (int i = 1; i <= 4; i++) begin
         drv(32'h8000_0014, 32'd0, 1'b0, 1'b1, 1'b1);
         chk("drain_data", bus.out_data, 32'(i));
         tick();
      end
      drv(32'h8000_000C, 32'd0, 1'b0, 1'b1, 1'b1);
      chk("drained_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("status_ovf_empty", bus.rdata, 32'h0000_0028); tick();
      drv(32'h8000_0010, 32'd1, 1'b1, 1'b0, 1'b1); tick();
      drv(32'h8000_000C, 32'd0, 1'b0, 1'b0, 1'b1); chk("ovf_cleared", bus.rdata, 32'h0000_0008); tick();

      // Full FIFO with simultaneous push and pop.
      for (int i = 1; i <= 4; i++) push(32'(i), 1'b0);
      push(32'd9, 1'b1);
      drv(32'h8000_000C, 32'd0, 1'b0, 1'b0, 1'b1); chk("full_pushpop", bus.rdata, 32'h0000_0014); tick();
      exp5[0] = 32'd2; exp5[1] = 32'd3; exp5[2] = 32'd4; exp5[3] = 32'd9;
      for (int i = 0; i < 4; i++) begin
         drv(32'h8000_0018, 32'd0, 1'b0, 1'b1, 1'b1);
         chk("pushpop_order", bus.out_data, exp5[i]); tick();
      end

      // Reset mid-operation, with an LED write presented during reset.
      for (int i = 1; i <= 3; i++) push(32'(i + 16), 1'b0);
      drv(32'h8000_0004, 32'h0000_ABCD, 1'b1, 1'b0, 1'b0); tick();
      drv(32'h8000_000C, 32'd0, 1'b0, 1'b0, 1'b1);
      chk("midreset_status", bus.rdata, 32'h0000_0008);
      chk("midreset_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("midreset_leds", {16'd0, bus.leds}, 32'd0); tick();

      // Randomized traffic checked against the model.
      for (int n = 0; n < 600; n++) begin
         logic [31:0] a, d;
         logic w, rdy, rst;
         a = $urandom;
         if ($urandom_range(0, 2) != 0) a[31] = 1'b1;
         if (a[31] && $urandom_range(0, 3) != 0) a[4:2] = 3'($urandom_range(0, 4));
         if (a[31] && a[4:2] == 3'd2 && $urandom_range(0, 1) != 0) a[4:2] = 3'd2;
         d = $urandom;
         w = ($urandom_range(0, 1) != 0);
         rdy = ($urandom_range(0, 2) == 0);
         rst = ($urandom_range(0, 60) != 0);
         drv(a, d, w, rdy, rst);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
